// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between an instruction-fetch requester and
//            a load/store requester, round-robin on ties, with an ack timeout.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ack,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_err,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int c_STRB_W = DATA_W / 8;
    // The counter only has to reach TIMEOUT-1: the timeout fires on that cycle.
    localparam int c_CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic                   r_last_d;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_mem_we;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [DATA_W-1:0]      r_mem_wdata;
    logic [c_STRB_W-1:0]    r_mem_wstrb;
    logic                   r_i_ack;
    logic                   r_d_ack;
    logic                   r_i_err;
    logic                   r_d_err;
    logic [DATA_W-1:0]      r_i_rdata;
    logic [DATA_W-1:0]      r_d_rdata;

    logic                   w_busy;
    logic                   w_grant_d;
    logic                   w_grant_i;
    logic                   w_timeout;

    // On a tie the port that did not win last time is served.
    assign w_grant_d = d_req & (~i_req | ~r_last_d);
    assign w_grant_i = i_req & ~w_grant_d;
    assign w_busy    = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
    assign w_timeout = w_busy & ~mem_ack & (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_next = ST_BUSY_D;
                end else if (w_grant_i) begin
                    w_next = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (mem_ack) begin
                    w_next = ST_RESP;
                end else if (w_timeout) begin
                    w_next = ST_IDLE;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d    <= 1'b0;
            r_cnt       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_err     <= 1'b0;
            r_d_err     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_i_ack <= (r_state == ST_BUSY_I) & mem_ack;
            r_d_ack <= (r_state == ST_BUSY_D) & mem_ack;
            r_i_err <= (r_state == ST_BUSY_I) & w_timeout;
            r_d_err <= (r_state == ST_BUSY_D) & w_timeout;

            if (r_state == ST_IDLE) begin
                if (w_grant_d) begin
                    r_last_d    <= 1'b1;
                    r_cnt       <= '0;
                    r_mem_we    <= d_we;
                    r_mem_addr  <= d_addr;
                    r_mem_wdata <= d_wdata;
                    r_mem_wstrb <= d_wstrb;
                end else if (w_grant_i) begin
                    r_last_d    <= 1'b0;
                    r_cnt       <= '0;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= i_addr;
                    r_mem_wdata <= '0;
                    r_mem_wstrb <= '0;
                end
            end

            if (w_busy && !mem_ack && !w_timeout) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            // Stores capture too; the load/store side ignores that data.
            if ((r_state == ST_BUSY_I) && mem_ack) begin
                r_i_rdata <= mem_rdata;
            end
            if ((r_state == ST_BUSY_D) && mem_ack) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = w_busy;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_err     = r_i_err;
    assign d_err     = r_d_err;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed vector table, hand sequences and a randomized run checked
//            against a transaction-level reference of mem_port_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit          ireq;
        bit          dreq;
        bit          dwe;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ack_at;     // BUSY cycle (1-based) carrying mem_ack
        logic [31:0] rdata;
        bit          exp_d;      // granted port: 1 = D, 0 = I
        bit          exp_ack;    // 1 = ack, 0 = timeout error
        logic [31:0] exp_addr;
        bit          exp_we;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_mem_req"}, mem_req, 1'b0);
        chk({name, "_flags"}, {i_ack, d_ack, i_err, d_err}, 4'b0000);
    endtask

    // Applies one table record starting from an IDLE cycle.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        bit    done;
        tag = $sformatf("vec%0d", idx);
        i_req = v.ireq; i_addr = v.iaddr;
        d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.wdata; d_wstrb = v.wstrb;
        tick();
        chk({tag, "_grant_req"}, mem_req, 1'b1);
        chk({tag, "_grant_addr"}, mem_addr, v.exp_addr);
        chk({tag, "_grant_we"}, mem_we, v.exp_we);
        chk({tag, "_grant_wdata"}, mem_wdata, v.exp_wdata);
        chk({tag, "_grant_wstrb"}, mem_wstrb, v.exp_wstrb);
        done = 1'b0;
        for (int j = 1; !done && j <= c_TIMEOUT; j++) begin
            if (j == v.ack_at) begin
                mem_ack = 1'b1;
                mem_rdata = v.rdata;
            end
            tick();
            mem_ack = 1'b0;
            if (j == v.ack_at) begin
                done = 1'b1;
                chk({tag, "_ack_flags"}, {i_ack, d_ack, i_err, d_err},
                    {!v.exp_d, v.exp_d, 2'b00});
                chk({tag, "_ack_mem_req"}, mem_req, 1'b0);
                if (!v.exp_d) chk({tag, "_i_rdata"}, i_rdata, v.rdata);
                else if (!v.dwe) chk({tag, "_d_rdata"}, d_rdata, v.rdata);
            end else if (j == c_TIMEOUT) begin
                done = 1'b1;
                chk({tag, "_err_flags"}, {i_ack, d_ack, i_err, d_err},
                    {2'b00, !v.exp_d, v.exp_d});
                chk({tag, "_err_mem_req"}, mem_req, 1'b0);
            end else begin
                chk({tag, "_busy_req"}, mem_req, 1'b1);
                chk({tag, "_busy_addr"}, mem_addr, v.exp_addr);
                chk({tag, "_busy_wdata"}, mem_wdata, v.exp_wdata);
                chk({tag, "_busy_flags"}, {i_ack, d_ack, i_err, d_err}, 4'b0000);
            end
        end
        chk({tag, "_outcome"}, (v.ack_at <= c_TIMEOUT), v.exp_ack);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        chk_quiet({tag, "_after"});
    endtask

    // Transaction-level reference state for the random run
    bit          m_busy, m_resp, m_port, m_last;
    int          m_j, m_ack_at, ev;
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
    logic [3:0]  m_wstrb;
    bit          m_we, m_dvalid;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 4'h0, 4, 32'h00500093,
                    1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 4'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, 4'b0011, 3, 32'h12345678,
                    1'b1, 1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 4'b0011};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h55, 4'hF, 1, 32'hCAFEF00D,
                    1'b1, 1'b1, 32'h200, 1'b0, 32'h55, 4'hF};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 4'h0, 15, 32'hA5A5A5A5,
                    1'b0, 1'b1, 32'h44, 1'b0, 32'h0, 4'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h300, 32'h11223344, 4'b1100, 99, 32'h0,
                    1'b1, 1'b0, 32'h300, 1'b1, 32'h11223344, 4'b1100};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 4'h0, 99, 32'h0,
                    1'b0, 1'b0, 32'h48, 1'b0, 32'h0, 4'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h4C, 32'h400, 32'h77, 4'hF, 2, 32'h0BADF00D,
                    1'b1, 1'b1, 32'h400, 1'b0, 32'h77, 4'hF};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h50, 32'h500, 32'h99, 4'h1, 5, 32'h13579BDF,
                    1'b0, 1'b1, 32'h50, 1'b0, 32'h0, 4'h0};

        // Reset state
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_wstrb", mem_wstrb, 4'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_flags", {i_ack, d_ack, i_err, d_err}, 4'b0000);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        rst = 1'b0;

        foreach (vecs[k]) run_vec(k, vecs[k]);

        // Both requests held through four transactions: D, I, D, I
        do_reset();
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr%0d_req", k), mem_req, 1'b1);
            chk($sformatf("rr%0d_addr", k), mem_addr, (k % 2 == 0) ? 32'h100 : 32'h40);
            mem_ack = 1'b1;
            mem_rdata = 32'h1000 + k;
            tick();
            mem_ack = 1'b0;
            chk($sformatf("rr%0d_ack", k), {i_ack, d_ack}, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        chk_quiet("rr_after");

        // Reset in the middle of a fetch, then a late mem_ack
        do_reset();
        i_req = 1'b1; i_addr = 32'h80;
        tick();
        tick();
        chk("mid_busy", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1 chk("mid_async_drop", mem_req, 1'b0);
        i_req = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF0000;
        tick();
        chk_quiet("mid_in_rst");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_quiet($sformatf("mid_post%0d", k));
        end
        chk("mid_i_rdata", i_rdata, 32'h0);
        mem_ack = 1'b0;
        run_vec(100, vecs[0]);

        // Randomized run against the transaction-level reference
        do_reset();
        m_busy = 1'b0; m_resp = 1'b0; m_last = 1'b0; m_port = 1'b0;
        m_j = 0; m_ack_at = 0; ev = 0;
        m_addr = '0; m_wdata = '0; m_wstrb = '0; m_we = 1'b0;
        m_irdata = '0; m_drdata = '0; m_dvalid = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int ev_n;
            bit gp;
            chk("rnd_mem_req", mem_req, m_busy);
            chk("rnd_flags", {i_ack, d_ack, i_err, d_err},
                {ev == 1, ev == 2, ev == 3, ev == 4});
            chk("rnd_i_rdata", i_rdata, m_irdata);
            if (m_dvalid) chk("rnd_d_rdata", d_rdata, m_drdata);
            if (m_busy) begin
                chk("rnd_mem_addr", mem_addr, m_addr);
                chk("rnd_mem_we", mem_we, m_we);
                chk("rnd_mem_wdata", mem_wdata, m_wdata);
                chk("rnd_mem_wstrb", mem_wstrb, m_wstrb);
            end

            if (ev == 1 || ev == 3) i_req = 1'b0;
            else if (!i_req && ($urandom % 4 == 0)) begin
                i_req = 1'b1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (ev == 2 || ev == 4) d_req = 1'b0;
            else if (!d_req && ($urandom % 4 == 0)) begin
                d_req = 1'b1;
                d_we = 1'($urandom % 2);
                d_addr = $urandom;
                d_wdata = $urandom;
                d_wstrb = 4'($urandom);
            end
            mem_ack = m_busy ? (m_j == m_ack_at) : 1'($urandom % 3 == 0);
            mem_rdata = $urandom;

            ev_n = 0;
            if (m_busy) begin
                if (mem_ack) begin
                    ev_n = m_port ? 2 : 1;
                    if (m_port) begin
                        m_drdata = mem_rdata;
                        m_dvalid = !m_we;
                    end else begin
                        m_irdata = mem_rdata;
                    end
                    m_busy = 1'b0;
                    m_resp = 1'b1;
                end else if (m_j == c_TIMEOUT) begin
                    ev_n = m_port ? 4 : 3;
                    m_busy = 1'b0;
                end else begin
                    m_j++;
                end
            end else if (m_resp) begin
                m_resp = 1'b0;
            end else if (i_req || d_req) begin
                gp = (i_req && d_req) ? !m_last : d_req;
                m_port = gp;
                m_last = gp;
                m_busy = 1'b1;
                m_j = 1;
                m_addr  = gp ? d_addr : i_addr;
                m_we    = gp ? d_we : 1'b0;
                m_wdata = gp ? d_wdata : 32'h0;
                m_wstrb = gp ? d_wstrb : 4'h0;
                if ($urandom % 8 == 0) m_ack_at = 99;
                else if ($urandom % 8 == 0) m_ack_at = c_TIMEOUT;
                else m_ack_at = int'($urandom_range(1, 6));
            end
            ev = ev_n;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; the byte-strobe width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 15, the maximum number of cycles to wait for mem_ack.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 i_req  in  1 / i_addr  in  ADDR_W: instruction-fetch read request and its address.
REQ-007 i_ack  out  1 / i_rdata  out  DATA_W / i_err  out  1: fetch completion pulse, read data and timeout pulse.
REQ-008 d_req  in  1 / d_we  in  1 / d_addr  in  ADDR_W / d_wdata  in  DATA_W / d_wstrb  in  DATA_W/8: load/store request.
REQ-009 d_ack  out  1 / d_rdata  out  DATA_W / d_err  out  1: load/store completion pulse, load data and timeout pulse.
REQ-010 mem_req  out  1 / mem_we  out  1 / mem_addr  out  ADDR_W / mem_wdata  out  DATA_W / mem_wstrb  out  DATA_W/8: single shared memory port.
REQ-011 mem_ack  in  1 / mem_rdata  in  DATA_W: memory completion strobe and read data.

Function
REQ-012 SHALL implement the FSM states IDLE, BUSY_I, BUSY_D and RESP.
REQ-013 In IDLE, if exactly one of i_req or d_req is high, SHALL go to the matching BUSY_x on the next edge.
REQ-014 In IDLE, if i_req and d_req are both high, SHALL grant the port not granted last (round-robin); after reset the last-granted port is I, so D wins the first tie.
REQ-015 On entering BUSY_x, SHALL register the port's address, we, wdata and wstrb into mem_*; for the I port, SHALL drive mem_we=0, mem_wstrb=0 and mem_wdata=0.
REQ-016 mem_req SHALL be high in every BUSY_x cycle and low in all other states; mem_* SHALL stay stable while mem_req is high.
REQ-017 In BUSY_x with mem_ack=1, SHALL capture mem_rdata into x_rdata, go to RESP and drive x_ack=1 for exactly one cycle (the RESP cycle).
REQ-018 Latency: request sampled at edge 0 -> mem_req high from cycle 1; mem_ack in cycle k -> x_ack high in cycle k+1; minimum request-to-ack is 2 cycles.
REQ-019 RESP SHALL always return to IDLE on the next edge; the arbiter SHALL ignore requests during RESP.
REQ-020 The requester SHALL drop x_req in its x_ack cycle; a request still high in IDLE afterwards is a new transaction.
REQ-021 x_rdata SHALL hold its value until that port's next capture; d_rdata SHALL be updated on stores too, with don't-care content.
REQ-022 A wait counter SHALL clear on entering BUSY_x and increment each BUSY_x cycle without mem_ack; when it reaches TIMEOUT, SHALL drop mem_req, pulse x_err for one cycle (no x_ack) and go to IDLE.
REQ-023 mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success (ack beats err).
REQ-024 mem_ack outside BUSY_x SHALL be ignored.
REQ-025 i_ack, d_ack, i_err and d_err SHALL never be high in the same cycle; a port with no granted transaction SHALL never see ack or err.
REQ-026 The last-granted pointer SHALL update on grant, including grants that later time out.

Reset
REQ-027 While rst=1, SHALL hold state IDLE and drive mem_req=0, mem_we=0, mem_wstrb=0, i_ack=0, d_ack=0, i_err=0, d_err=0, i_rdata=0, d_rdata=0, mem_addr=0, mem_wdata=0, the wait counter at 0 and last-granted = I.
REQ-028 Reset asserted mid-transaction SHALL drop mem_req immediately (asynchronously), abandon the transaction without any ack or err, and leave later mem_ack pulses ignored.

Verification
REQ-029 i_req only, i_addr=0x40, mem_ack 3 cycles after mem_req, mem_rdata=0x00500093 -> mem_addr=0x40, mem_we=0, i_ack one cycle later, i_rdata=0x00500093.
REQ-030 d_req store with d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=4'b0011 -> mem_we=1, mem_wstrb=0011, mem_wdata=0xDEADBEEF held until mem_ack; d_ack pulses once.
REQ-031 i_req and d_req both held continuously for 4 transactions after reset -> grant order D, I, D, I.
REQ-032 d_req with mem_ack never asserted, TIMEOUT=15 -> mem_req high for 15 cycles, then d_err pulses once, no d_ack, FSM back to IDLE.
REQ-033 rst pulsed during BUSY_I, then mem_ack arrives -> mem_req=0 during reset, no i_ack or i_err, next i_req is served normally.
REQ-034 mem_ack in the same cycle the counter hits TIMEOUT -> x_ack=1 and x_err=0.
